// File: rtl/interpreter_uart_tx.sv
// fifo: circular word buffer with wrap-bit pointers; push accepted when full if a pop happens the same cycle.
// Latency: a written word is visible on rd_dat the cycle after the push; count/empty follow pointers directly.
// Backpressure: none upstream; a push while full without a pop is ignored (the caller flags the loss).
module fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic             wr_en;
    logic             rd_en;

    assign rd_en  = pop & ~empty;
    assign wr_en  = push & (~full | rd_en);
    assign wr_nxt = wr_ptr + {{AW{1'b0}}, wr_en};
    assign rd_nxt = rd_ptr + {{AW{1'b0}}, rd_en};
    assign empty  = (wr_ptr == rd_ptr);
    assign count  = wr_ptr - rd_ptr;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; full is registered from the next-state pointer difference.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= ((wr_nxt - rd_nxt) == DEPTH_P);
        end
    end

    // Storage write; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end
endmodule

// interpreter_uart_tx: captures strobed 15-bit words into a FIFO and sends each as two 8N1 bytes (low, then {0,high}).
// Latency: push 3 clk edges after data_valid rises; tx falls 1 cycle after the pop; one word takes 20*CLKS_PER_BIT cycles.
// Backpressure: none on the strobe; words arriving while the FIFO is full are dropped and overflow sticks high.
module interpreter_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               data_valid,
    input  logic [14:0]                        data_in,
    output logic                               tx,
    output logic                               busy,
    output logic                               fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic            byte_sel_q, byte_sel_d;
    logic [14:0]     word_q, word_d;
    logic            tx_q, tx_d;
    logic [7:0]      cur_byte;

    logic            sync1, sync2, sync3;
    logic            push;
    logic            pop;
    logic [14:0]     rd_dat;
    logic            empty;
    logic [AW:0]     count;
    logic            overflow_q;

    // Two-flop synchronizer plus one delay stage for rising-edge detection of the async strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= data_valid;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // data_in is sampled raw: upstream holds it stable well past the detect cycle.
    assign push = sync2 & ~sync3;

    fifo #(
        .WIDTH (15),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_dat (data_in),
        .rd_dat (rd_dat),
        .full   (fifo_full),
        .empty  (empty),
        .count  (count)
    );

    // Sticky loss flag: a push that the FIFO could not take.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Serializer state register; tx is registered from the next-state view so it lines up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            word_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state, pop request and next tx level.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        pop        = 1'b0;
        tx_d       = 1'b1;
        cur_byte   = 8'h00;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    word_d     = rd_dat;
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        cur_byte = byte_sel_d ? {1'b0, word_d[14:8]} : word_d[7:0];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) | ~empty;
    assign fifo_count = CW'(count);
    assign overflow   = overflow_q;
endmodule

// File: doc/interpreter_uart_tx.md
Name: interpreter_uart_tx

Overview:
- Downstream consumer of the processor's interpreter-communication stage.
- Captures each 15-bit word that stage publishes on its output strobe and buffers it in a small FIFO.
- Serializes each word as two 8N1 UART bytes toward the host interpreter.
- Decouples bursty store-to-COM traffic from the slow serial link and flags lost words.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2
FIFO_DEPTH, 8, words buffered; power of two, >= 2

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_valid  input  1  word strobe from the communication stage; not synchronous to clk, level held >= 3 clk cycles
data_in  input  15  word from the communication stage; stable from data_valid rise until its next rise
tx  output  1  UART serial line, idle high
busy  output  1  1 while a frame is in progress or the FIFO is non-empty
fifo_full  output  1  FIFO holds FIFO_DEPTH words
fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently buffered
overflow  output  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (reset = 0, asynchronous):
  - tx = 1; busy = 0; fifo_full = 0; fifo_count = 0; overflow = 0.
  - FIFO pointers cleared; FSM forced to IDLE; synchronizer flops cleared to 0.
  - Reset mid-frame aborts the frame immediately: tx returns high, pending words are discarded.
- Strobe capture:
  - data_valid passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - Exactly one push per rising edge of data_valid, regardless of how long it is held high.
  - The push writes data_in into the FIFO on the detect cycle, which is the 3rd clk edge after data_valid rises.
  - data_in is sampled directly, not synchronized; its stability is guaranteed by the upstream contract.
- FIFO:
  - Circular buffer of FIFO_DEPTH x 15 bits.
  - Read and write pointers have one extra wrap bit; full/empty are derived from the pointers.
  - Push while full and no pop in the same cycle: word dropped, overflow set to 1 until reset, pointers unchanged.
  - Simultaneous push and pop: both performed, and the push is accepted even when full. fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM (states IDLE, START, DATA, STOP; byte_sel register selects low or high byte):
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head word into a 15-bit word register, set byte_sel = 0 and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte bit[index], LSB first, CLKS_PER_BIT cycles per bit, 8 bits total, then go to STOP.
    - byte_sel = 0 sends word[7:0].
    - byte_sel = 1 sends {1'b0, word[14:8]}.
  - STOP: tx = 1 for CLKS_PER_BIT cycles.
    - If byte_sel = 0: set byte_sel = 1 and go to START.
    - Otherwise: go to IDLE.
  - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit transition.
  - One word = 20 bit periods = 20 x CLKS_PER_BIT cycles, plus 1 IDLE cycle before the next pop.
  - Latency: tx falls 1 cycle after the pop; a push into an empty FIFO while IDLE pops on the following cycle.
- Outputs:
  - tx, fifo_full and overflow are registered.
  - busy = (state != IDLE) | ~empty.
  - fifo_count = wr_ptr - rd_ptr, using the extended pointers.

Test Plan:
- Reset values: hold reset = 0 for 5 cycles -> tx = 1, busy = 0, fifo_count = 0, overflow = 0. Release reset -> outputs unchanged while idle.
- Single word: CLKS_PER_BIT = 4, pulse data_valid with data_in = 15'h1234 -> tx shows start bit 0, bits 0,0,1,0,1,1,0,0 (0x34), stop 1, then start 0, bits 0,1,0,0,1,0,0,0 (0x12), stop 1. Total 80 cycles of frame, then busy = 0.
- Held strobe: hold data_valid high for 50 cycles with data_in = 15'h7FFF -> exactly one push; bytes 0xFF then 0x7F sent; fifo_count never exceeds 1.
- Burst / overflow: FIFO_DEPTH = 8, CLKS_PER_BIT = 4, 10 strobes spaced 4 cycles apart with values 1..10 -> fifo_full asserts and overflow = 1. Only the words accepted before full (1..9: one is popped early) are transmitted, in order. Word 10 is never transmitted.
- Wrap-around: 20 words spaced 100 cycles apart (CLKS_PER_BIT = 4) -> all 20 received in order, overflow = 0, fifo_count returns to 0.
- Reset mid-frame: assert reset = 0 during the DATA state of byte 1 with 3 words queued -> tx = 1 immediately, fifo_count = 0. After release, no bytes are emitted until a new strobe arrives.
